// File: rtl/exp2_pkg.sv
// Shared types and constants for the exp2 (antilog) converter.
// The fixed-point log format matches the log2 block.
package exp2_pkg;

    localparam int FRAC_BITS = 5;
    localparam int INT_BITS  = 3;
    localparam int MANT_W    = 16;
    localparam int K_W       = $clog2(FRAC_BITS + 1);
    localparam int SCALE_W   = 24;

    typedef logic [2:-5]        fixed_t;
    typedef logic [MANT_W-1:0]  mant_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SCALE
    } state_t;

    localparam mant_t ONE_Q15 = 16'h8000;

    // round(2^(2^-k) * 2^15): the factor contributed by fraction bit x[-k]
    localparam mant_t EXP2_FRAC_ROOTS [1:FRAC_BITS] = '{
        16'd46341, 16'd38968, 16'd35734, 16'd34219, 16'd33486
    };

endpackage

// File: rtl/exp2_mul_q15.sv
// Combinational Q1.15 x Q1.15 multiply, rounded half-up back to Q1.15.
module exp2_mul_q15
    import exp2_pkg::*;
(
    input  mant_t a,
    input  mant_t b,
    output mant_t y
);

    logic [31:0] w_prod;
    logic [31:0] w_sum;

    always_comb begin
        w_prod = 32'(a) * 32'(b);
        w_sum  = w_prod + 32'd16384;
        y      = MANT_W'(w_sum >> 15);
    end

endmodule

// File: rtl/exp2.sv
// Iterative 2^x: multiplies in one root constant per set fraction bit,
// then shifts by the integer part and rounds to an 8-bit integer.
module exp2
    import exp2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  fixed_t     fixed_point_in,
    input  logic       zeroflag_in,
    output logic [7:0] int_out,
    output logic       ready,
    output logic       busy
);

    state_t                r_state;
    logic [K_W-1:0]        r_k;
    mant_t                 r_m;
    logic [INT_BITS-1:0]   r_int;
    logic [FRAC_BITS-1:0]  r_frac;
    logic                  r_zero;
    logic [7:0]            r_int_out;
    logic                  r_ready;
    logic                  r_busy;

    mant_t                 w_coef;
    logic                  w_bit;
    mant_t                 w_prod;
    logic [SCALE_W-1:0]    w_scaled;
    logic [SCALE_W-1:0]    w_round;
    logic [7:0]            w_sat;

    // r_frac[FRAC_BITS-1] holds x[-1], so x[-k] sits at r_frac[FRAC_BITS-k]
    always_comb begin
        w_coef = ONE_Q15;
        w_bit  = 1'b0;
        for (int i = 1; i <= FRAC_BITS; i++) begin
            if (r_k == K_W'(i)) begin
                w_coef = EXP2_FRAC_ROOTS[i];
                w_bit  = r_frac[FRAC_BITS-i];
            end
        end
    end

    exp2_mul_q15 u_mul (
        .a (r_m),
        .b (w_coef),
        .y (w_prod)
    );

    always_comb begin
        w_scaled = SCALE_W'(r_m) << r_int;
        w_round  = (w_scaled + SCALE_W'(16384)) >> 15;
        w_sat    = (w_round > SCALE_W'(255)) ? 8'hFF : w_round[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_m       <= '0;
            r_int     <= '0;
            r_frac    <= '0;
            r_zero    <= 1'b0;
            r_int_out <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_int   <= fixed_point_in[2:0];
                        r_frac  <= fixed_point_in[-1:-5];
                        r_zero  <= zeroflag_in;
                        r_m     <= ONE_Q15;
                        r_k     <= K_W'(1);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    if (w_bit) begin
                        r_m <= w_prod;
                    end
                    r_k <= r_k + K_W'(1);
                    if (r_k == K_W'(FRAC_BITS)) begin
                        r_state <= SCALE;
                    end
                end
                SCALE: begin
                    r_int_out <= r_zero ? 8'd0 : w_sat;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign int_out = r_int_out;
    assign ready   = r_ready;
    assign busy    = r_busy;

endmodule

// File: tb/tb_exp2.sv
// Scoreboard bench for exp2: stimulus pushes expected results, a monitor
// pops and compares on each rising edge of ready.
module tb_exp2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] fixed_point_in;
    logic       zeroflag_in;
    logic [7:0] int_out;
    logic       ready;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic       prev_ready = 1'b0;

    exp2 dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .fixed_point_in (fixed_point_in),
        .zeroflag_in    (zeroflag_in),
        .int_out        (int_out),
        .ready          (ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: one comparison per completed conversion
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ready = 1'b0;
            end else begin
                if (ready && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got %0d expected none", int_out);
                    end else begin
                        chk("result", int'(int_out), int'(exp_q.pop_front()));
                    end
                end
                prev_ready = ready;
            end
        end
    end

    // Called just after a posedge; returns #1 after the capture edge E0
    task automatic issue(input logic [7:0] x, input logic zf, input logic [7:0] e, input string name);
        fixed_point_in = x;
        zeroflag_in    = zf;
        start          = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start          = 1'b0;
        fixed_point_in = ~x;
        zeroflag_in    = ~zf;
        chk({name, "_busy_at_E0"}, int'(busy), 1);
        chk({name, "_ready_low_E0"}, int'(ready), 0);
    endtask

    task automatic wait_done(input string name, input int already);
        int cyc;
        cyc = already;
        while (!ready && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!ready && cyc < 6 && busy !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL %s_busy_mid: got %0b expected 1 at cycle %0d", name, busy, cyc);
            end
        end
        chk({name, "_latency"}, cyc, 6);
        chk({name, "_busy_done"}, int'(busy), 0);
        @(negedge clk);
    endtask

    // Spec arithmetic, used for the round-trip expectations
    function automatic int model_exp2(input logic [7:0] x, input logic zf);
        longint m;
        longint r;
        longint c [1:5];
        c[1] = 46341; c[2] = 38968; c[3] = 35734; c[4] = 34219; c[5] = 33486;
        m = 32768;
        for (int k = 1; k <= 5; k++) begin
            if (x[5-k]) m = (m * c[k] + 16384) >> 15;
        end
        r = ((m << x[7:5]) + 16384) >> 15;
        if (r > 255) r = 255;
        if (zf) r = 0;
        return int'(r);
    endfunction

    function automatic logic [7:0] log2_fixed(input int n);
        int k;
        int f;
        k = 0;
        while ((2 << k) <= n) k++;
        f = 0;
        for (int j = 1; j < 32; j++) begin
            if ($pow(2.0, real'(k) + real'(j) / 32.0) <= real'(n) + 1.0e-9) f = j;
        end
        return {k[2:0], f[4:0]};
    endfunction

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        fixed_point_in = 8'h00;
        zeroflag_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_int_out", int'(int_out), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results
        issue(8'h00, 1'b0, 8'd1,   "x00");   wait_done("x00", 0);
        @(posedge clk); #1;
        issue(8'h60, 1'b0, 8'd8,   "x60");   wait_done("x60", 0);
        @(posedge clk); #1;
        issue(8'h10, 1'b0, 8'd1,   "x10");   wait_done("x10", 0);
        @(posedge clk); #1;
        issue(8'h90, 1'b0, 8'd23,  "x90");   wait_done("x90", 0);
        @(posedge clk); #1;
        issue(8'hF4, 1'b0, 8'd197, "xF4");   wait_done("xF4", 0);
        @(posedge clk); #1;
        issue(8'hFF, 1'b0, 8'd251, "xFF");   wait_done("xFF", 0);
        @(posedge clk); #1;
        issue(8'hFF, 1'b1, 8'd0,   "zero");  wait_done("zero", 0);
        @(posedge clk); #1;

        // Start while busy is ignored
        issue(8'h60, 1'b0, 8'd8, "ign");
        @(posedge clk); #1;
        @(posedge clk); #1;
        fixed_point_in = 8'hFF;
        zeroflag_in    = 1'b0;
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
        wait_done("ign", 3);

        // Back-to-back start while ready is held
        issue(8'h10, 1'b0, 8'd1, "b2b");
        chk("b2b_int_out_held", int'(int_out), 8);
        wait_done("b2b", 0);
        @(posedge clk); #1;

        // Reset mid-conversion discards the partial result
        fixed_point_in = 8'hFF;
        zeroflag_in    = 1'b0;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_int_out", int'(int_out), 0);
        chk("rst_mid_ready", int'(ready), 0);
        chk("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_stale", int'(ready), 0);
        issue(8'h60, 1'b0, 8'd8, "post_rst"); wait_done("post_rst", 0);
        @(posedge clk); #1;

        // Round-trip through a log2 reference
        for (int t = 0; t < 8; t++) begin
            int n;
            logic [7:0] lx;
            int ideal;
            n     = int'($urandom_range(1, 255));
            lx    = log2_fixed(n);
            ideal = int'($floor($pow(2.0, real'(lx) / 32.0) + 0.5));
            if (ideal != model_exp2(lx, 1'b0))
                $display("round-trip note: n=%0d x=0x%02h ideal=%0d hw-arith=%0d", n, lx, ideal, model_exp2(lx, 1'b0));
            issue(lx, 1'b0, 8'(model_exp2(lx, 1'b0)), "rt");
            wait_done("rt", 0);
            @(posedge clk); #1;
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
